uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader_if.sv | 24 ++
 rtl/uart_boot_loader.sv | 120 ++++++++++++
 tb/tb_uart_boot_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: byte-stream, imem write port and core control signals of the boot loader
interface uart_boot_loader_if #(
    parameter int IADDR_W = 15
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               tx_busy;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               imem_we;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_rst;
    logic               load_done;
    logic               err;
    modport master (
        output rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start, imem_we, imem_addr, imem_wdata, core_rst, load_done, err
    );
    modport slave (
        input  rx_data, rx_valid, tx_busy,
        output tx_data, tx_start, imem_we, imem_addr, imem_wdata, core_rst, load_done, err
    );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a framed UART program image into imem, then acks and releases the core
module uart_boot_loader #(
    parameter int         IADDR_W  = 15,
    parameter logic [7:0] MAGIC    = 8'h99,
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input logic                clk,
    input logic                rst,
    uart_boot_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SIZE, DATA, ACK, RUN, ERR} state_e;
    state_e             state_q;
    logic [1:0]         cnt_q;
    logic [31:0]        n_q;
    logic [31:0]        asm_q;
    logic [IADDR_W:0]   k_q;
    logic               last_q;
    logic               we_q;
    logic [IADDR_W-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic               core_rst_q;
    logic               done_q;
    logic               err_q;
    logic [31:0]        n_d;
    logic [31:0]        asm_d;
    logic               n_bad_d;
    // Bytes arrive LSB first, so both shift registers fill from the top
    assign n_d     = {bus.rx_data, n_q[31:8]};
    assign asm_d   = {bus.rx_data, asm_q[31:8]};
    assign n_bad_d = (n_d == 32'd0) || ({1'b0, n_d} > (33'd1 << IADDR_W));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            asm_q      <= '0;
            k_q        <= '0;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == MAGIC) begin
                        state_q <= SIZE;
                        cnt_q   <= '0;
                    end
                end
                SIZE: begin
                    if (bus.rx_valid) begin
                        n_q   <= n_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= n_bad_d ? ERR : DATA;
                            err_q   <= err_q | n_bad_d;
                            k_q     <= '0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    we_q <= 1'b0;
                    // The last write cycle still counts as DATA; leave only after it
                    if (we_q && last_q) begin
                        state_q <= ACK;
                    end else if (bus.rx_valid) begin
                        asm_q <= asm_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= k_q[IADDR_W-1:0];
                            wdata_q <= asm_d;
                            k_q     <= k_q + 1'b1;
                            last_q  <= 32'(k_q) == n_q - 32'd1;
                        end
                    end
                end
                ACK: begin
                    if (tx_start_q) begin
                        tx_start_q <= 1'b0;
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= ACK_BYTE;
                    end
                end
                ERR: begin
                    if (tx_start_q) begin
                        tx_start_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= ERR_BYTE;
                    end
                end
                RUN: ;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.load_done  = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven frames plus timing sequences for the UART boot loader
module tb_uart_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  txq[$];
    always #5 clk = ~clk;
    uart_boot_loader_if #(.IADDR_W(4)) bus();
    uart_boot_loader #(.IADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        bit           do_rst;
        int           nb;
        int           gap;
        logic [127:0] b;
        int           nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [7:0]   tx;
        bit           e;
        bit           d;
    } vec_t;
    vec_t tbl[6];
    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa.push_back(32'(bus.imem_addr));
            wd.push_back(bus.imem_wdata);
        end
        if (bus.tx_start) txq.push_back(bus.tx_data);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] qa(input int i);
        return (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qd(input int i);
        return (i < wd.size()) ? wd[i] : 32'hFFFF_FFFF;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        wa.delete();
        wd.delete();
        txq.delete();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_core_rst"}, 32'(bus.core_rst), 1);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 0);
        check({tag, "_load_done"}, 32'(bus.load_done), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    endtask
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask
    task automatic wait_tx(input string tag);
        int n = 0;
        while (txq.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_tx_seen"}, 32'(txq.size() > 0), 1);
        repeat (3) tick();
    endtask
    initial begin
        vec_t r;
        tbl[0] = '{1'b1, 13, 0, 128'h99_02000000_78563412_EFBEADDE_000000, 2, 32'h12345678, 32'hDEADBEEF, 8'hAA, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 11, 2, 128'h0041_99_01000000_04030201_0000000000, 1, 32'h01020304, 32'h0, 8'hAA, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 5, 1, 128'h9900_0000_0000_0000_0000_0000_0000_0000, 0, 32'h0, 32'h0, 8'hEE, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 9, 0, 128'h99_01000000_11223344_00000000000000, 1, 32'h44332211, 32'h0, 8'hAA, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 5, 3, 128'h99_11000000_0000000000000000000000, 0, 32'h0, 32'h0, 8'hEE, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 5, 0, 128'h99_10000001_0000000000000000000000, 0, 32'h0, 32'h0, 8'hEE, 1'b1, 1'b0};
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        do_reset();
        check_reset("por");
        for (int t = 0; t < 6; t++) begin
            string tag;
            r = tbl[t];
            tag = $sformatf("vec%0d", t);
            if (r.do_rst) do_reset();
            clr();
            for (int i = 0; i < r.nb; i++) begin
                send_byte(r.b[127-8*i -: 8]);
                repeat (r.gap) tick();
            end
            wait_tx(tag);
            check({tag, "_nwrites"}, 32'(wa.size()), 32'(r.nw));
            if (r.nw >= 1) begin
                check({tag, "_addr0"}, qa(0), 0);
                check({tag, "_data0"}, qd(0), r.w0);
            end
            if (r.nw >= 2) begin
                check({tag, "_addr1"}, qa(1), 1);
                check({tag, "_data1"}, qd(1), r.w1);
            end
            check({tag, "_ntx"}, 32'(txq.size()), 1);
            check({tag, "_txbyte"}, 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'(r.tx));
            check({tag, "_err"}, 32'(bus.err), 32'(r.e));
            check({tag, "_load_done"}, 32'(bus.load_done), 32'(r.d));
            check({tag, "_core_rst"}, 32'(bus.core_rst), 32'(!r.d));
        end
        // Full memory: N=16 words at 0..15
        do_reset();
        clr();
        send_byte(8'h99);
        send_word(32'd16);
        for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 | 32'(i * 17));
        wait_tx("full");
        check("full_nwrites", 32'(wa.size()), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_addr%0d", i), qa(i), 32'(i));
            check($sformatf("full_data%0d", i), qd(i), 32'hC0DE_0000 | 32'(i * 17));
        end
        check("full_txbyte", 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'hAA);
        check("full_load_done", 32'(bus.load_done), 1);
        // Back-to-back bytes with transmitter busy: ack and release wait for tx_busy
        do_reset();
        clr();
        bus.tx_busy = 1'b1;
        send_byte(8'h99);
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        check("busy_we", 32'(bus.imem_we), 1);
        check("busy_addr", 32'(bus.imem_addr), 0);
        check("busy_wdata", bus.imem_wdata, 32'hCAFEF00D);
        repeat (20) tick();
        check("busy_no_tx", 32'(txq.size()), 0);
        check("busy_core_rst", 32'(bus.core_rst), 1);
        check("busy_not_done", 32'(bus.load_done), 0);
        bus.tx_busy = 1'b0;
        tick();
        check("busy_tx_start", 32'(bus.tx_start), 1);
        check("busy_tx_data", 32'(bus.tx_data), 32'hAA);
        check("busy_core_rst_at_tx", 32'(bus.core_rst), 1);
        tick();
        check("busy_tx_start_off", 32'(bus.tx_start), 0);
        check("busy_core_rst_rel", 32'(bus.core_rst), 0);
        check("busy_done", 32'(bus.load_done), 1);
        // In RUN, a further frame is ignored
        clr();
        send_byte(8'h99);
        send_word(32'd1);
        send_word(32'h01020304);
        repeat (5) tick();
        check("run_nwrites", 32'(wa.size()), 0);
        check("run_ntx", 32'(txq.size()), 0);
        check("run_done", 32'(bus.load_done), 1);
        // Reset in the middle of a 3-word frame
        do_reset();
        send_byte(8'h99);
        send_word(32'd3);
        send_word(32'hDDCCBBAA);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        clr();
        send_byte(8'h99);
        send_word(32'd1);
        send_word(32'h01020304);
        wait_tx("fresh");
        check("fresh_nwrites", 32'(wa.size()), 1);
        check("fresh_addr0", qa(0), 0);
        check("fresh_data0", qd(0), 32'h01020304);
        check("fresh_txbyte", 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'hAA);
        check("fresh_done", 32'(bus.load_done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
